// File: rtl/tv80_mem_arbiter.sv
// tv80_mem_arbiter: TV80 memory decode with per-region latency and CPU/GPU frame-buffer arbitration
//   clk, reset_n             : clock, asynchronous active-low reset
//   ready, cpu_*             : TV80 bus cycle in; cpu_wait_n stretches it
//   gpu_req, gpu_addr_a/b    : GPU FB read pair request; gpu_gnt/gpu_valid report issue/data
//   rom_*, ram_*, fb_*       : block-RAM ports; *_di_valid flags CPU read data
//   unmapped                 : pulse on a CPU access above RAM_TOP
module tv80_mem_arbiter #(
    parameter int          ROM_AW    = 14,
    parameter int          FB_AW     = 11,
    parameter int          RAM_AW    = 12,
    parameter logic [15:0] FB_BASE   = 16'h4000,
    parameter logic [15:0] RAM_BASE  = 16'h4800,
    parameter logic [15:0] RAM_TOP   = 16'h50FF,
    parameter int          ROM_LAT   = 1,
    parameter int          RAM_LAT   = 2,
    parameter int          FB_LAT    = 1,
    parameter int          MAX_DEFER = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ready,
    input  logic [15:0]       cpu_addr_in,
    input  logic              cpu_mreq_n,
    input  logic              cpu_wr_n,
    input  logic              gpu_req,
    input  logic [FB_AW-1:0]  gpu_addr_a,
    input  logic [FB_AW-1:0]  gpu_addr_b,
    output logic [ROM_AW-1:0] rom_addra,
    output logic              rom_ena,
    output logic [RAM_AW-1:0] ram_addra,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [FB_AW-1:0]  fb_addra,
    output logic              fb_ena,
    output logic              fb_wea,
    output logic [FB_AW-1:0]  fb_addrb,
    output logic              fb_enb,
    output logic              rom_di_valid,
    output logic              ram_di_valid,
    output logic              fb_di_valid,
    output logic              cpu_wait_n,
    output logic              gpu_gnt,
    output logic              gpu_valid,
    output logic              unmapped
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    typedef enum logic [1:0] {R_ROM, R_FB, R_RAM, R_UNM} region_t;
    localparam int MAX_LAT = (ROM_LAT > RAM_LAT ? (ROM_LAT > FB_LAT ? ROM_LAT : FB_LAT)
                                                : (RAM_LAT > FB_LAT ? RAM_LAT : FB_LAT));
    localparam int LW = $clog2(MAX_LAT + 1);
    localparam int DW = $clog2(MAX_DEFER + 1);
    localparam logic [31:0] ROM_END = 32'(1) << ROM_AW;
    localparam logic [31:0] FB_END  = 32'(FB_BASE) + (32'(1) << FB_AW);
    state_t            state, state_n;
    region_t           region_q, dec, cur_region;
    logic [15:0]       addr_q, cur_addr;
    logic              wr_q;
    logic [LW-1:0]     lat_cnt, lat_n, lat_issue;
    logic [DW-1:0]     defer_cnt, defer_n;
    logic [FB_LAT-1:0] gv_q;
    logic              cpu_req, fb_raw, gpu_wins, issue, cpu_act, cpu_fb, ack_rd;
    always_comb begin
        dec        = 32'(cpu_addr_in) < ROM_END ? R_ROM :
                     (cpu_addr_in >= FB_BASE && 32'(cpu_addr_in) < FB_END) ? R_FB :
                     (cpu_addr_in >= RAM_BASE && cpu_addr_in <= RAM_TOP) ? R_RAM : R_UNM;
        cur_region = state == IDLE ? dec : region_q;
        cur_addr   = state == IDLE ? cpu_addr_in : addr_q;
        cpu_req    = ~cpu_mreq_n & ready & reset_n;
        fb_raw     = ~cpu_mreq_n & (dec == R_FB);
        // A pending CPU FB access yields to the GPU until it has deferred MAX_DEFER times
        gpu_wins   = state == IDLE && cpu_req && dec == R_FB && gpu_req && defer_cnt < DW'(MAX_DEFER);
        issue      = state == IDLE && cpu_req && !gpu_wins;
        cpu_act    = issue || state != IDLE;
        cpu_fb     = cpu_act && cur_region == R_FB;
        gpu_gnt    = gpu_req & reset_n & ~cpu_fb;
        lat_issue  = dec == R_ROM ? LW'(ROM_LAT - 1) : dec == R_FB ? LW'(FB_LAT - 1) :
                     dec == R_RAM ? LW'(RAM_LAT - 1) : '0;
        state_n    = issue ? (lat_issue != '0 ? WAIT : ACK) :
                     state == WAIT ? (lat_cnt <= LW'(1) ? ACK : WAIT) :
                     (state == ACK && cpu_mreq_n) ? IDLE : state;
        lat_n      = issue ? lat_issue : state == WAIT ? lat_cnt - 1'b1 : lat_cnt;
        defer_n    = gpu_wins ? defer_cnt + 1'b1 : (issue || !fb_raw) ? '0 : defer_cnt;
        ack_rd     = state == ACK && !wr_q;
    end
    assign rom_ena      = cpu_act && cur_region == R_ROM;
    assign rom_addra    = ROM_AW'(cur_addr);
    assign ram_ena      = cpu_act && cur_region == R_RAM;
    assign ram_wea      = issue && dec == R_RAM && !cpu_wr_n;
    assign ram_addra    = RAM_AW'(cur_addr - RAM_BASE);
    assign fb_ena       = cpu_fb | gpu_gnt;
    assign fb_wea       = issue && dec == R_FB && !cpu_wr_n;
    assign fb_addra     = gpu_gnt ? gpu_addr_a : FB_AW'(cur_addr - FB_BASE);
    assign fb_enb       = gpu_gnt;
    assign fb_addrb     = gpu_addr_b;
    assign rom_di_valid = ack_rd && region_q == R_ROM;
    assign ram_di_valid = ack_rd && region_q == R_RAM;
    assign fb_di_valid  = ack_rd && region_q == R_FB;
    assign cpu_wait_n   = reset_n & (state == ACK || (state == IDLE && ready && cpu_mreq_n));
    assign unmapped     = issue && dec == R_UNM;
    assign gpu_valid    = gv_q[FB_LAT-1];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            defer_cnt <= '0;
            gv_q      <= '0;
            addr_q    <= '0;
            region_q  <= R_UNM;
            wr_q      <= 1'b0;
        end else begin
            state     <= state_n;
            lat_cnt   <= lat_n;
            defer_cnt <= defer_n;
            gv_q      <= FB_LAT'({gv_q, gpu_gnt});
            if (issue) begin
                addr_q   <= cpu_addr_in;
                region_q <= dec;
                wr_q     <= ~cpu_wr_n;
            end
        end
    end
endmodule

// File: tb/tb_tv80_mem_arbiter.sv
// tb_tv80_mem_arbiter: directed checks of decode, latency, GPU arbitration and reset
module tb_tv80_mem_arbiter;
    logic        clk = 0, reset_n = 0, ready = 1, cpu_mreq_n = 1, cpu_wr_n = 1, gpu_req = 0;
    logic [15:0] cpu_addr_in = '0;
    logic [10:0] gpu_addr_a = '0, gpu_addr_b = '0;
    logic [13:0] rom_addra;
    logic [11:0] ram_addra;
    logic [10:0] fb_addra, fb_addrb;
    logic rom_ena, ram_ena, ram_wea, fb_ena, fb_wea, fb_enb;
    logic rom_di_valid, ram_di_valid, fb_di_valid, cpu_wait_n, gpu_gnt, gpu_valid, unmapped;
    int checks = 0, failures = 0;

    tv80_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n), .ready(ready), .cpu_addr_in(cpu_addr_in),
        .cpu_mreq_n(cpu_mreq_n), .cpu_wr_n(cpu_wr_n), .gpu_req(gpu_req),
        .gpu_addr_a(gpu_addr_a), .gpu_addr_b(gpu_addr_b),
        .rom_addra(rom_addra), .rom_ena(rom_ena), .ram_addra(ram_addra), .ram_ena(ram_ena),
        .ram_wea(ram_wea), .fb_addra(fb_addra), .fb_ena(fb_ena), .fb_wea(fb_wea),
        .fb_addrb(fb_addrb), .fb_enb(fb_enb), .rom_di_valid(rom_di_valid),
        .ram_di_valid(ram_di_valid), .fb_di_valid(fb_di_valid), .cpu_wait_n(cpu_wait_n),
        .gpu_gnt(gpu_gnt), .gpu_valid(gpu_valid), .unmapped(unmapped)
    );

    always #5 clk = ~clk;

    wire [12:0] flags = {rom_ena, ram_ena, ram_wea, fb_ena, fb_wea, fb_enb, rom_di_valid,
                         ram_di_valid, fb_di_valid, cpu_wait_n, gpu_gnt, gpu_valid, unmapped};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic finish_cycle;
        tick();
        cpu_mreq_n = 1;
        cpu_wr_n = 1;
        tick();
    endtask

    task automatic test_reset;
        cpu_mreq_n = 0;
        gpu_req = 1;
        @(negedge clk);
        checks++;
        if (flags !== 13'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=%b", flags, 13'b0);
        end
        cpu_mreq_n = 1;
        gpu_req = 0;
        reset_n = 1;
        tick();
        checks++;
        if ({cpu_wait_n, rom_ena, fb_ena} !== 3'b100) begin
            failures++;
            $display("FAIL reset_release_idle got=%b want=100", {cpu_wait_n, rom_ena, fb_ena});
        end
    endtask

    task automatic test_rom_read(input logic [15:0] a);
        cpu_addr_in = a;
        cpu_mreq_n = 0;
        @(negedge clk);
        checks++;
        if ({rom_ena, rom_addra, cpu_wait_n, rom_di_valid} !== {1'b1, a[13:0], 2'b00}) begin
            failures++;
            $display("FAIL rom_issue a=%h got=%b/%h/%b/%b want=1/%h/0/0", a, rom_ena, rom_addra,
                     cpu_wait_n, rom_di_valid, a[13:0]);
        end
        tick();
        checks++;
        if ({rom_ena, cpu_wait_n, rom_di_valid, ram_ena, fb_ena} !== 5'b11100) begin
            failures++;
            $display("FAIL rom_ack got=%b want=11100", {rom_ena, cpu_wait_n, rom_di_valid, ram_ena, fb_ena});
        end
        finish_cycle();
        checks++;
        if ({rom_ena, cpu_wait_n, rom_di_valid} !== 3'b010) begin
            failures++;
            $display("FAIL rom_back_idle got=%b want=010", {rom_ena, cpu_wait_n, rom_di_valid});
        end
    endtask

    task automatic test_ram(input logic [15:0] a, input logic wr, input logic [11:0] off);
        cpu_addr_in = a;
        cpu_mreq_n = 0;
        cpu_wr_n = ~wr;
        @(negedge clk);
        checks++;
        if ({ram_ena, ram_wea, ram_addra, cpu_wait_n} !== {1'b1, wr, off, 1'b0}) begin
            failures++;
            $display("FAIL ram_issue a=%h got=%b/%b/%h/%b want=1/%b/%h/0", a, ram_ena, ram_wea,
                     ram_addra, cpu_wait_n, wr, off);
        end
        tick();
        checks++;
        if ({ram_ena, ram_wea, cpu_wait_n, ram_di_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL ram_wait got=%b want=1000", {ram_ena, ram_wea, cpu_wait_n, ram_di_valid});
        end
        tick();
        checks++;
        if ({ram_ena, ram_wea, cpu_wait_n, ram_di_valid} !== {3'b101, ~wr}) begin
            failures++;
            $display("FAIL ram_ack got=%b want=101%b", {ram_ena, ram_wea, cpu_wait_n, ram_di_valid}, ~wr);
        end
        finish_cycle();
    endtask

    task automatic test_gpu_priority;
        gpu_req = 1;
        gpu_addr_a = 11'h07A;
        gpu_addr_b = 11'h07B;
        cpu_addr_in = 16'h4010;
        cpu_mreq_n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({gpu_gnt, fb_ena, fb_enb, fb_addra, fb_addrb, fb_wea, cpu_wait_n} !==
                {3'b111, 11'h07A, 11'h07B, 2'b00}) begin
                failures++;
                $display("FAIL gpu_defer%0d got gnt=%b ena=%b enb=%b a=%h b=%h we=%b wait_n=%b want 1 1 1 07a 07b 0 0",
                         i, gpu_gnt, fb_ena, fb_enb, fb_addra, fb_addrb, fb_wea, cpu_wait_n);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if ({gpu_gnt, fb_ena, fb_enb, fb_addra, cpu_wait_n} !== {3'b010, 11'h010, 1'b0}) begin
            failures++;
            $display("FAIL cpu_fb_issue got gnt=%b ena=%b enb=%b a=%h wait_n=%b want 0 1 0 010 0",
                     gpu_gnt, fb_ena, fb_enb, fb_addra, cpu_wait_n);
        end
        tick();
        checks++;
        if ({gpu_gnt, fb_di_valid, cpu_wait_n, gpu_valid} !== 4'b0110) begin
            failures++;
            $display("FAIL cpu_fb_ack got=%b want=0110", {gpu_gnt, fb_di_valid, cpu_wait_n, gpu_valid});
        end
        gpu_req = 0;
        finish_cycle();
    endtask

    task automatic test_fb_write;
        cpu_addr_in = 16'h47FF;
        cpu_mreq_n = 0;
        cpu_wr_n = 0;
        @(negedge clk);
        checks++;
        if ({fb_ena, fb_wea, fb_enb, fb_addra} !== {3'b110, 11'h7FF}) begin
            failures++;
            $display("FAIL fb_write got=%b/%b/%b/%h want=1/1/0/7ff", fb_ena, fb_wea, fb_enb, fb_addra);
        end
        tick();
        checks++;
        if ({fb_ena, fb_wea, fb_di_valid, cpu_wait_n} !== 4'b1001) begin
            failures++;
            $display("FAIL fb_write_ack got=%b want=1001", {fb_ena, fb_wea, fb_di_valid, cpu_wait_n});
        end
        finish_cycle();
    endtask

    task automatic test_unmapped(input logic [15:0] a);
        cpu_addr_in = a;
        cpu_mreq_n = 0;
        @(negedge clk);
        checks++;
        if ({unmapped, rom_ena, ram_ena, fb_ena, cpu_wait_n} !== 5'b10000) begin
            failures++;
            $display("FAIL unmapped_issue a=%h got=%b want=10000", a, {unmapped, rom_ena, ram_ena, fb_ena, cpu_wait_n});
        end
        tick();
        checks++;
        if ({unmapped, cpu_wait_n, rom_di_valid, ram_di_valid, fb_di_valid} !== 5'b01000) begin
            failures++;
            $display("FAIL unmapped_ack a=%h got=%b want=01000", a,
                     {unmapped, cpu_wait_n, rom_di_valid, ram_di_valid, fb_di_valid});
        end
        finish_cycle();
    endtask

    task automatic test_gpu_pulses;
        for (int i = 0; i < 3; i++) begin
            gpu_req = 1;
            gpu_addr_a = 11'(i);
            gpu_addr_b = 11'(11'h100 + i);
            @(negedge clk);
            checks++;
            if ({gpu_gnt, fb_addrb, fb_addra, gpu_valid} !== {1'b1, 11'(11'h100 + i), 11'(i), i != 0}) begin
                failures++;
                $display("FAIL gpu_pulse%0d got gnt=%b b=%h a=%h valid=%b", i, gpu_gnt, fb_addrb, fb_addra, gpu_valid);
            end
            tick();
        end
        gpu_req = 0;
        @(negedge clk);
        checks++;
        if ({gpu_gnt, fb_ena, gpu_valid} !== 3'b001) begin
            failures++;
            $display("FAIL gpu_tail_valid got=%b want=001", {gpu_gnt, fb_ena, gpu_valid});
        end
        tick();
        checks++;
        if (gpu_valid !== 1'b0) begin
            failures++;
            $display("FAIL gpu_valid_end got=%b want=0", gpu_valid);
        end
    endtask

    task automatic test_ready_low;
        ready = 0;
        cpu_addr_in = 16'h0010;
        cpu_mreq_n = 0;
        @(negedge clk);
        checks++;
        if ({cpu_wait_n, rom_ena} !== 2'b00) begin
            failures++;
            $display("FAIL ready_low_stall got=%b want=00", {cpu_wait_n, rom_ena});
        end
        tick();
        ready = 1;
        @(negedge clk);
        checks++;
        if ({rom_ena, rom_addra} !== {1'b1, 14'h0010}) begin
            failures++;
            $display("FAIL ready_resume got=%b/%h want=1/0010", rom_ena, rom_addra);
        end
        finish_cycle();
    endtask

    task automatic test_reset_mid_wait;
        cpu_addr_in = 16'h4900;
        cpu_mreq_n = 0;
        tick();
        @(negedge clk);
        checks++;
        if ({ram_ena, cpu_wait_n} !== 2'b10) begin
            failures++;
            $display("FAIL mid_wait_state got=%b want=10", {ram_ena, cpu_wait_n});
        end
        #1 reset_n = 0;
        #1;
        checks++;
        if (flags !== 13'b0) begin
            failures++;
            $display("FAIL reset_mid_wait got=%b want=%b", flags, 13'b0);
        end
        cpu_mreq_n = 1;
        tick();
        @(negedge clk);
        reset_n = 1;
        tick();
        test_rom_read(16'h3FFF);
    endtask

    initial begin
        test_reset();
        test_rom_read(16'h0123);
        test_ram(16'h4805, 1'b1, 12'h005);
        test_ram(16'h50FF, 1'b0, 12'h8FF);
        test_gpu_priority();
        test_fb_write();
        test_unmapped(16'h6000);
        test_unmapped(16'h5100);
        test_gpu_pulses();
        test_ready_low();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
